// File: rtl/tty_pkg.sv
// Shared constants and FSM state type for the TTY UART transmitter.
package tty_pkg;

  localparam int unsigned CLKS_PER_BIT_DEFAULT = 868;
  localparam int unsigned FIFO_DEPTH_DEFAULT   = 4;
  localparam int unsigned TTY_CHAR_W           = 7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tty_tx_state_e;

endpackage

// File: rtl/tty_char_fifo.sv
// Character FIFO with wrap-around pointers, occupancy count and registered flags.
module tty_char_fifo
  import tty_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH_DEFAULT,
  parameter int unsigned WIDTH = TTY_CHAR_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count, count_n;
  logic             push_ok, pop_ok;

  // Acceptance uses the flags as they stood before the edge, so a push while
  // full is dropped even if a pop frees a slot in the same cycle.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_comb begin
    count_n = count;
    if (flush)
      count_n = '0;
    else if (push_ok && !pop_ok)
      count_n = count + (AW + 1)'(1);
    else if (pop_ok && !push_ok)
      count_n = count - (AW + 1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      count <= count_n;
      full  <= (count_n == DEPTH_C);
      empty <= (count_n == '0);
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + AW'(1);
        if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/tty_uart_tx.sv
// TTY character output: edge-detected writes into a FIFO, drained as 8N1 UART frames.
module tty_uart_tx
  import tty_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int unsigned FIFO_DEPTH   = FIFO_DEPTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [TTY_CHAR_W-1:0] TTY_data,
  input  logic                  TTY_en,
  input  logic                  TTY_clear,
  output logic                  TTY_ready,
  output logic                  tx,
  output logic                  tx_busy
);

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  logic [1:0]            rst_sync;
  logic                  rst_n;
  logic                  en_d;
  logic                  push, pop;
  logic                  fifo_full, fifo_empty;
  logic [TTY_CHAR_W-1:0] fifo_dout;

  tty_tx_state_e state, state_n;
  logic [15:0]   baud_cnt, baud_cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shreg, shreg_n;
  logic          tx_n;

  // Assertion is immediate; release is delayed by two clocks.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) en_d <= 1'b0;
    else        en_d <= TTY_en;
  end

  assign push = TTY_en && !en_d && !TTY_clear;

  tty_char_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (TTY_CHAR_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (TTY_clear),
    .din   (TTY_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // tx_n is the line level for the cycle after the edge, so tx is a plain flop.
  always_comb begin
    state_n    = state;
    baud_cnt_n = baud_cnt + 16'd1;
    bit_idx_n  = bit_idx;
    shreg_n    = shreg;
    tx_n       = tx;
    pop        = 1'b0;
    unique case (state)
      ST_IDLE: begin
        baud_cnt_n = '0;
        tx_n       = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shreg_n = {1'b0, fifo_dout};
          state_n = ST_START;
          tx_n    = 1'b0;
        end
      end
      ST_START: begin
        if (baud_cnt == BAUD_LAST) begin
          state_n    = ST_DATA;
          baud_cnt_n = '0;
          bit_idx_n  = '0;
          tx_n       = shreg[0];
        end
      end
      ST_DATA: begin
        if (baud_cnt == BAUD_LAST) begin
          baud_cnt_n = '0;
          if (bit_idx == 3'd7) begin
            state_n = ST_STOP;
            tx_n    = 1'b1;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
            tx_n      = shreg[bit_idx_n];
          end
        end
      end
      ST_STOP: begin
        if (baud_cnt == BAUD_LAST) begin
          state_n    = ST_IDLE;
          baud_cnt_n = '0;
          tx_n       = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    if (TTY_clear) begin
      state_n    = ST_IDLE;
      baud_cnt_n = '0;
      bit_idx_n  = '0;
      tx_n       = 1'b1;
      pop        = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_cnt_n;
      bit_idx  <= bit_idx_n;
      shreg    <= shreg_n;
      tx       <= tx_n;
    end
  end

  assign TTY_ready = !fifo_full;
  assign tx_busy   = (state != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_tty_uart_tx.sv
// Scoreboard bench for tty_uart_tx: written characters are queued and matched against decoded frames.
module tb_tty_uart_tx;

  localparam int unsigned CPB = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] TTY_data;
  logic       TTY_en;
  logic       TTY_clear;
  logic       TTY_ready;
  logic       tx;
  logic       tx_busy;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [6:0]  sb [$];
  time         start_q [$];
  int unsigned n_frames = 0;
  logic        mon_on   = 1'b0;
  logic        mon_busy = 1'b0;
  logic [6:0]  burst [6] = '{7'h31, 7'h7F, 7'h00, 7'h2A, 7'h5A, 7'h66};
  int unsigned base;

  always #5 clk = ~clk;

  tty_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .TTY_data  (TTY_data),
    .TTY_en    (TTY_en),
    .TTY_clear (TTY_clear),
    .TTY_ready (TTY_ready),
    .tx        (tx),
    .tx_busy   (tx_busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_idle(input int unsigned max_cyc);
    int unsigned n = 0;
    while ((tx_busy || mon_busy) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check_eq("wait_idle", {31'd0, tx_busy | mon_busy}, 0);
  endtask

  // Frame decoder: every cycle of every bit must hold the same level.
  initial begin : monitor
    logic [9:0]  fb;
    int unsigned unstable;
    logic [6:0]  exp_c;
    forever begin
      @(negedge clk);
      if (mon_on && tx === 1'b0) begin
        mon_busy = 1'b1;
        start_q.push_back($time);
        n_frames++;
        unstable = 0;
        fb = '0;
        for (int b = 0; b < 10; b++) begin
          for (int k = 0; k < int'(CPB); k++) begin
            if (b != 0 || k != 0) @(negedge clk);
            if (k == 0) fb[b] = tx;
            else if (tx !== fb[b]) unstable++;
          end
        end
        check_eq("bit_stable", unstable, 0);
        check_eq("stop_bit", {31'd0, fb[9]}, 1);
        check_eq("sb_nonempty", {31'd0, sb.size() != 0}, 1);
        if (sb.size() != 0) begin
          exp_c = sb.pop_front();
          check_eq("frame_data", {24'd0, fb[8:1]}, {25'd0, exp_c});
        end
        mon_busy = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    TTY_data  = '0;
    TTY_en    = 1'b0;
    TTY_clear = 1'b0;
    reset     = 1'b1;
    #1 reset  = 1'b0;
    @(negedge clk);
    check_eq("rst_tx", {31'd0, tx}, 1);
    check_eq("rst_ready", {31'd0, TTY_ready}, 1);
    check_eq("rst_busy", {31'd0, tx_busy}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    mon_on = 1'b1;

    // Single character: latency and frame length
    base = n_frames;
    TTY_data = 7'h41; TTY_en = 1'b1; sb.push_back(7'h41);
    @(negedge clk);
    TTY_en = 1'b0;
    check_eq("lat_pre_tx", {31'd0, tx}, 1);
    check_eq("busy_rise", {31'd0, tx_busy}, 1);
    @(negedge clk);
    check_eq("lat_tx_fall", {31'd0, tx}, 0);
    repeat (39) @(negedge clk);
    check_eq("busy_last_cycle", {31'd0, tx_busy}, 1);
    @(negedge clk);
    check_eq("busy_fall", {31'd0, tx_busy}, 0);
    check_eq("idle_tx", {31'd0, tx}, 1);
    wait_idle(100);
    check_eq("frames_single", n_frames - base, 1);

    // Held enable gives one write
    base = n_frames;
    @(negedge clk);
    TTY_data = 7'h55; TTY_en = 1'b1; sb.push_back(7'h55);
    repeat (10) @(negedge clk);
    TTY_en = 1'b0;
    wait_idle(400);
    repeat (20) @(negedge clk);
    check_eq("frames_held_en", n_frames - base, 1);
    check_eq("sb_drained_held", sb.size(), 0);

    // Burst of six writes: FIFO fills, sixth dropped, one idle cycle between frames
    base = n_frames;
    start_q.delete();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      TTY_data = burst[i]; TTY_en = 1'b1;
      if (i < 5) sb.push_back(burst[i]);
      @(negedge clk);
      TTY_en = 1'b0;
      check_eq($sformatf("ready_w%0d", i), {31'd0, TTY_ready}, (i >= 4) ? 0 : 1);
    end
    wait_idle(400);
    check_eq("frames_burst", n_frames - base, 5);
    check_eq("starts_burst", start_q.size(), 5);
    for (int i = 1; i < start_q.size(); i++)
      check_eq($sformatf("gap_%0d", i), 32'(start_q[i] - start_q[i-1]), 41 * 10);
    check_eq("sb_drained_burst", sb.size(), 0);
    check_eq("ready_after_burst", {31'd0, TTY_ready}, 1);

    // Clear during data bit 3 with two characters queued
    mon_on = 1'b0;
    @(negedge clk);                                    // A
    TTY_data = 7'h04; TTY_en = 1'b1;
    @(negedge clk); TTY_en = 1'b0;                     // A+1
    @(negedge clk); TTY_data = 7'h42; TTY_en = 1'b1;   // A+2
    @(negedge clk); TTY_en = 1'b0;                     // A+3
    @(negedge clk); TTY_data = 7'h43; TTY_en = 1'b1;   // A+4
    @(negedge clk); TTY_en = 1'b0;                     // A+5
    check_eq("ready_two_queued", {31'd0, TTY_ready}, 1);
    repeat (12) @(negedge clk);                        // A+17, bit 2
    check_eq("clr_bit2", {31'd0, tx}, 1);
    @(negedge clk);                                    // A+18, bit 3
    check_eq("clr_bit3", {31'd0, tx}, 0);
    @(negedge clk);                                    // A+19
    check_eq("clr_bit3_hold", {31'd0, tx}, 0);
    TTY_clear = 1'b1; TTY_en = 1'b1; TTY_data = 7'h44;
    @(negedge clk);                                    // A+20
    TTY_clear = 1'b0;
    check_eq("clr_tx", {31'd0, tx}, 1);
    check_eq("clr_ready", {31'd0, TTY_ready}, 1);
    check_eq("clr_busy", {31'd0, tx_busy}, 0);
    repeat (2) @(negedge clk);
    TTY_en = 1'b0;
    begin
      int unsigned lows = 0, busys = 0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (tx !== 1'b1) lows++;
        if (tx_busy !== 1'b0) busys++;
      end
      check_eq("clr_no_resume_tx", lows, 0);
      check_eq("clr_no_resume_busy", busys, 0);
    end
    mon_on = 1'b1;

    // Reset mid-STOP, then normal operation
    base = n_frames;
    @(negedge clk);                                    // A
    TTY_data = 7'h5A; TTY_en = 1'b1; sb.push_back(7'h5A);
    @(negedge clk); TTY_en = 1'b0;                     // A+1
    repeat (38) @(negedge clk);                        // A+39, mid STOP
    reset = 1'b0;
    #1;
    check_eq("rst_mid_tx", {31'd0, tx}, 1);
    check_eq("rst_mid_ready", {31'd0, TTY_ready}, 1);
    check_eq("rst_mid_busy", {31'd0, tx_busy}, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq($sformatf("rst_hold_tx_%0d", i), {31'd0, tx}, 1);
      check_eq($sformatf("rst_hold_busy_%0d", i), {31'd0, tx_busy}, 0);
    end
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("rst_rel_ready", {31'd0, TTY_ready}, 1);
    TTY_data = 7'h3C; TTY_en = 1'b1; sb.push_back(7'h3C);
    @(negedge clk);
    TTY_en = 1'b0;
    @(negedge clk);
    check_eq("rst_rel_tx_fall", {31'd0, tx}, 0);
    wait_idle(200);
    check_eq("frames_reset", n_frames - base, 2);
    check_eq("sb_final", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
